// File: rtl/ts_pkg.sv
// Shared defaults and helper functions for the timestamper request arbiter.
// Covers the ID/timestamp widths, the owner index width and the lowest-set-bit encoder.
package ts_pkg;
    localparam int ID_W_DEF = 3;
    localparam int TS_W_DEF = 8;
    localparam int POOL_MAX = 256;

    function automatic int owner_idx_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Lowest set bit; callers zero-extend their pool bitmap to POOL_MAX.
    function automatic logic [7:0] lsb_idx(input logic [POOL_MAX-1:0] v);
        logic [7:0] r;
        r = '0;
        for (int k = POOL_MAX - 1; k >= 0; k--)
            if (v[k]) r = 8'(k);
        return r;
    endfunction
endpackage

// File: rtl/ts_req_arbiter_rr_arbiter.sv
// N-wide round-robin arbiter: the first requester at or after i_ptr gets the one-hot grant.
// It also reports the grant index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx
);
    always_comb begin
        int idx;
        o_gnt = '0;
        o_idx = '0;
        idx   = 0;
        // Walk from farthest to nearest so the nearest requester is the one that sticks.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(i_ptr) + k) % N;
            if (i_req[idx]) begin
                o_gnt      = '0;
                o_gnt[idx] = 1'b1;
                o_idx      = PW'(idx);
            end
        end
    end
endmodule

// File: rtl/ts_req_arbiter.sv
// Shares one event_timestamper between N_REQ requesters: ID allocation, RR arbitration, end ownership checks.
// Defining TS_ARB_STATS_EN adds the saturating stall_cnt/err_cnt output ports.
module ts_req_arbiter
    import ts_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = ID_W_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int OW    = owner_idx_w(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_start_valid,
    output logic [N_REQ-1:0]      req_start_ready,
    output logic [ID_W-1:0]       alloc_id,
    input  logic [N_REQ-1:0]      req_end_valid,
    output logic [N_REQ-1:0]      req_end_ready,
    input  logic [N_REQ*ID_W-1:0] req_end_id,
    output logic                  ts_start_valid,
    input  logic                  ts_start_ready,
    output logic [ID_W-1:0]       ts_start_id,
    output logic                  ts_end_valid,
    input  logic                  ts_end_ready,
    output logic [ID_W-1:0]       ts_end_id,
    input  logic                  ts_out_valid,
    input  logic                  ts_out_ready,
    input  logic [ID_W-1:0]       ts_out_id,
    output logic [OW-1:0]         out_owner,
    output logic                  end_err
`ifdef TS_ARB_STATS_EN
    ,output logic [TS_W-1:0]      stall_cnt,
    output logic [TS_W-1:0]       err_cnt
`endif
);
    localparam int POOL = 2 ** ID_W;

    logic [POOL-1:0]         r_free, r_pend;
    logic [POOL-1:0][OW-1:0] r_owner;
    logic [OW-1:0]           r_start_rr, r_end_rr;
    logic                    r_end_err;

    logic [N_REQ-1:0] w_sgnt, w_egnt;
    logic [OW-1:0]    w_sidx, w_eidx;
    logic [7:0]       w_lsb;
    logic [ID_W-1:0]  w_aid, w_eid;
    logic             w_s_any, w_e_any, w_free_any, w_legal;
    logic             w_s_fire, w_e_fire, w_drop, w_o_fire;

    rr_arbiter #(.N(N_REQ), .PW(OW)) u_start_rr (
        .i_req(req_start_valid), .i_ptr(r_start_rr), .o_gnt(w_sgnt), .o_idx(w_sidx));
    rr_arbiter #(.N(N_REQ), .PW(OW)) u_end_rr (
        .i_req(req_end_valid), .i_ptr(r_end_rr), .o_gnt(w_egnt), .o_idx(w_eidx));

    assign w_lsb      = lsb_idx(POOL_MAX'(r_free));
    assign w_aid      = w_lsb[ID_W-1:0];
    assign w_s_any    = |req_start_valid;
    assign w_e_any    = |req_end_valid;
    assign w_free_any = |r_free;
    assign w_eid      = req_end_id[int'(w_eidx)*ID_W +: ID_W];
    assign w_legal    = !r_free[w_eid] && !r_pend[w_eid] && (r_owner[w_eid] == w_eidx);

    assign ts_start_valid  = !rst && w_s_any && w_free_any;
    assign ts_start_id     = w_aid;
    assign alloc_id        = w_aid;
    assign req_start_ready = ts_start_valid ? (w_sgnt & {N_REQ{ts_start_ready}}) : '0;
    assign w_s_fire        = ts_start_valid && ts_start_ready;

    // Illegal ends are consumed locally so a bad requester cannot wedge the channel.
    assign ts_end_valid  = !rst && w_e_any && w_legal;
    assign ts_end_id     = w_eid;
    assign w_drop        = !rst && w_e_any && !w_legal;
    assign req_end_ready = rst ? '0 : (w_egnt & {N_REQ{w_legal ? ts_end_ready : 1'b1}});
    assign w_e_fire      = ts_end_valid && ts_end_ready;

    assign w_o_fire  = ts_out_valid && ts_out_ready;
    assign out_owner = r_owner[ts_out_id];
    assign end_err   = r_end_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_free     <= '1;
            r_pend     <= '0;
            r_owner    <= '0;
            r_start_rr <= '0;
            r_end_rr   <= '0;
            r_end_err  <= 1'b0;
        end else begin
            r_end_err <= w_drop;
            if (w_s_fire) begin
                r_free[w_aid]   <= 1'b0;
                r_owner[w_aid]  <= w_sidx;
                r_start_rr      <= OW'((int'(w_sidx) + 1) % N_REQ);
            end
            if (w_e_fire) r_pend[w_eid] <= 1'b1;
            if (w_e_fire || w_drop) r_end_rr <= OW'((int'(w_eidx) + 1) % N_REQ);
            if (w_o_fire) begin
                r_free[ts_out_id] <= 1'b1;
                r_pend[ts_out_id] <= 1'b0;
            end
        end
    end

`ifdef TS_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (w_s_any && !w_free_any && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (w_drop && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ts_req_arbiter.sv
// Directed bench for ts_req_arbiter: allocation order, ownership, pool exhaustion, dropped ends, reset.
// Stats checks compile in only when TS_ARB_STATS_EN is defined.
module tb_ts_req_arbiter;
    logic       clk = 0, rst = 1;
    logic [3:0] req_start_valid = 0, req_start_ready;
    logic [2:0] alloc_id;
    logic [3:0] req_end_valid = 0, req_end_ready;
    logic [11:0] req_end_id = 0;
    logic       ts_start_valid, ts_start_ready = 0;
    logic [2:0] ts_start_id;
    logic       ts_end_valid, ts_end_ready = 0;
    logic [2:0] ts_end_id;
    logic       ts_out_valid = 0, ts_out_ready = 0;
    logic [2:0] ts_out_id = 0;
    logic [1:0] out_owner;
    logic       end_err;
`ifdef TS_ARB_STATS_EN
    logic [7:0] stall_cnt, err_cnt;
`endif
    int n_chk = 0, n_pass = 0;

    ts_req_arbiter dut (
        .clk(clk), .rst(rst),
        .req_start_valid(req_start_valid), .req_start_ready(req_start_ready), .alloc_id(alloc_id),
        .req_end_valid(req_end_valid), .req_end_ready(req_end_ready), .req_end_id(req_end_id),
        .ts_start_valid(ts_start_valid), .ts_start_ready(ts_start_ready), .ts_start_id(ts_start_id),
        .ts_end_valid(ts_end_valid), .ts_end_ready(ts_end_ready), .ts_end_id(ts_end_id),
        .ts_out_valid(ts_out_valid), .ts_out_ready(ts_out_ready), .ts_out_id(ts_out_id),
        .out_owner(out_owner), .end_err(end_err)
`ifdef TS_ARB_STATS_EN
        , .stall_cnt(stall_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: requests present but everything forced quiet.
        req_start_valid = 4'b0111;
        ts_start_ready  = 1;
        tick(); #1;
        chk("rst_sready", 32'(req_start_ready), 32'h0);
        chk("rst_svalid", 32'(ts_start_valid), 32'h0);
        tick();
        rst = 0; #1;
        chk("rst_enderr", 32'(end_err), 32'h0);

        // 1: three starts, granted in order with IDs 0,1,2.
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_rdy%0d", i), 32'(req_start_ready), 32'(1 << i));
            chk($sformatf("t1_id%0d", i), 32'(alloc_id), 32'(i));
            chk($sformatf("t1_tsid%0d", i), 32'(ts_start_id), 32'(i));
            tick(); #1;
        end
        req_start_valid = 0;
        ts_out_id = 2; #1;
        chk("t1_owner2", 32'(out_owner), 32'd2);

        // 2: requester 1 ends ID 1, then the result is consumed.
        req_end_valid = 4'b0010;
        req_end_id[3 +: 3] = 3'd1;
        ts_end_ready = 1; #1;
        chk("t2_evalid", 32'(ts_end_valid), 32'h1);
        chk("t2_eid", 32'(ts_end_id), 32'd1);
        chk("t2_erdy", 32'(req_end_ready), 32'b0010);
        tick();
        req_end_valid = 0;
        ts_out_valid = 1; ts_out_ready = 1; ts_out_id = 1;
        req_start_valid = 4'b1000; ts_start_ready = 0; #1;
        chk("t2_enderr", 32'(end_err), 32'h0);
        chk("t2_owner", 32'(out_owner), 32'd1);
        chk("t2_id_during_free", 32'(alloc_id), 32'd3);
        tick();
        ts_out_valid = 0; ts_start_ready = 1; #1;
        chk("t2_reuse_id", 32'(alloc_id), 32'd1);
        chk("t2_reuse_rdy", 32'(req_start_ready), 32'b1000);
        tick(); #1;

        // 3: requester 3 drains the pool (IDs 3..7), then stalls.
        for (int i = 3; i < 8; i++) begin
            chk($sformatf("t3_id%0d", i), 32'(alloc_id), 32'(i));
            tick(); #1;
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_empty_v%0d", i), 32'(ts_start_valid), 32'h0);
            chk($sformatf("t3_empty_r%0d", i), 32'(req_start_ready), 32'h0);
            tick(); #1;
        end
`ifdef TS_ARB_STATS_EN
        chk("t3_stall_cnt", 32'(stall_cnt), 32'd5);
`endif
        ts_out_valid = 1; ts_out_id = 4; #1;
        chk("t3_free_cycle_v", 32'(ts_start_valid), 32'h0);
        tick();
        ts_out_valid = 0; #1;
        chk("t3_refill_v", 32'(ts_start_valid), 32'h1);
        chk("t3_refill_id", 32'(alloc_id), 32'd4);
        tick();
        req_start_valid = 0; #1;

        // 4: requester 2 ends ID 0, which requester 0 owns.
        req_end_valid = 4'b0100;
        req_end_id[6 +: 3] = 3'd0; #1;
        chk("t4_evalid", 32'(ts_end_valid), 32'h0);
        chk("t4_erdy", 32'(req_end_ready), 32'b0100);
        tick();
        req_end_valid = 0; #1;
        chk("t4_err_pulse", 32'(end_err), 32'h1);
        tick(); #1;
        chk("t4_err_clear", 32'(end_err), 32'h0);

        // 5: requester 3 ends ID 3 twice; first under backpressure.
        req_end_valid = 4'b1000;
        req_end_id[9 +: 3] = 3'd3;
        ts_end_ready = 0; #1;
        chk("t5_bp_valid", 32'(ts_end_valid), 32'h1);
        chk("t5_bp_rdy", 32'(req_end_ready), 32'h0);
        ts_end_ready = 1; #1;
        chk("t5_first_rdy", 32'(req_end_ready), 32'b1000);
        chk("t5_first_id", 32'(ts_end_id), 32'd3);
        tick(); #1;
        chk("t5_dup_valid", 32'(ts_end_valid), 32'h0);
        chk("t5_dup_rdy", 32'(req_end_ready), 32'b1000);
        tick();
        req_end_valid = 0; #1;
        chk("t5_dup_err", 32'(end_err), 32'h1);
`ifdef TS_ARB_STATS_EN
        chk("t5_err_cnt", 32'(err_cnt), 32'd2);
`endif

        // 6: reset with IDs outstanding; allocation restarts cleanly.
        rst = 1;
        req_start_valid = 4'b0111; #1;
        chk("t6_rst_rdy", 32'(req_start_ready), 32'h0);
        chk("t6_rst_v", 32'(ts_start_valid), 32'h0);
        tick();
        rst = 0; #1;
        chk("t6_rdy", 32'(req_start_ready), 32'b0001);
        chk("t6_id", 32'(alloc_id), 32'd0);
        chk("t6_enderr", 32'(end_err), 32'h0);
`ifdef TS_ARB_STATS_EN
        chk("t6_stall_clr", 32'(stall_cnt), 32'd0);
`endif
        tick(); #1;
        chk("t6_rdy1", 32'(req_start_ready), 32'b0010);
        chk("t6_id1", 32'(alloc_id), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
